// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, with the borrow carried between digits in a register. Operands are
// shifted right one digit per cycle so the active digit always sits in the
// low bits. The result is shifted in from the top, which leaves digit 0 at
// the bottom once all STEPS digits have been produced.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             a_msb, b_msb;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   dsub;
  logic [WIDTH-1:0] diff_nx;
  logic             last;

  // One digit of subtraction; the extra top bit of dsub is the borrow out.
  always_comb begin
    dsub    = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};
    diff_nx = diff >> DIGIT;
    diff_nx[WIDTH-1 -: DIGIT] = dsub[DIGIT-1:0];
    last    = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs; abort wins over completion/out_ready.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort || out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, digit-serial datapath and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
          end else begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            diff   <= diff_nx;
            borrow <= dsub[DIGIT];
            cnt    <= cnt + 1'b1;
            if (last) begin
              bout <= dsub[DIGIT];
              zero <= (diff_nx == '0);
              ovf  <= (a_msb != b_msb) && (diff_nx[WIDTH-1] != a_msb);
            end
          end
        end
        DONE: begin
          if (abort) begin
            bout <= 1'b0;
            zero <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
